spi_cfg_rw: RTL
===============

Name: spi_cfg_rw

Overview:
Parametrised SPI configuration master for board peripherals (clock generator, ADC, DAC, PLL).
- Accepts one command plus data word on an AXI-Stream-style slave handshake.
- Shifts out 1..DATA_WIDTH/8 bytes, MSB first, to one of N_SLAVES chip selects.
- Supports all four SPI modes, selected per transaction.
- Optionally captures MISO and returns the read-back word on an AXI-Stream master port.

Parameters:
CLK_DIV, 3, SCLK period = 2**CLK_DIV aclk cycles; half-period H = 2**(CLK_DIV-1); legal range 1..8.
N_SLAVES, 4, number of chip-select lines; legal range 1..4.
DATA_WIDTH, 32, transmit/read-back word width; multiple of 8, legal range 8..64.

Ports:
aclk  in  1  system clock
aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  DATA_WIDTH  transmit word, left-aligned (first bit = bit DATA_WIDTH-1)
s_axis_tvalid  in  1  command valid
s_axis_tready  out  1  block idle, command accepted on tvalid&&tready
cmd  in  8  [1:0] slave index, [4:2] nbytes-1, [5] read enable, [6] CPOL, [7] CPHA; sampled with tdata
cs  out  N_SLAVES  chip selects, active low
sclk  out  1  SPI clock
sdi  out  1  MOSI
sdo  in  1  MISO
m_axis_tdata  out  DATA_WIDTH  read-back word, right-aligned, upper bits zero
m_axis_tvalid  out  1  read-back valid
m_axis_tready  in  1  read-back accept

Behaviour:
- Reset (aresetn low, asynchronous):
  - cs all ones, sclk=0, sdi=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, FSM in IDLE.
  - s_axis_tready rises on the first aclk edge after release.
  - Reset mid-frame aborts immediately; no read-back is produced.
- Byte count: N bytes = cmd[4:2]+1, clamped to DATA_WIDTH/8. Bits = 8N.
- FSM: IDLE -> SETUP -> SHIFT -> HOLD -> (RESP if read) -> IDLE.
- IDLE:
  - s_axis_tready=1.
  - On tvalid&&tready, latch tdata and cmd, drop tready, go to SETUP.
  - While not accepting, sclk stays at the CPOL of the last frame.
- SETUP (H cycles):
  - cs[idx] low from the cycle after acceptance; sclk = CPOL.
  - CPHA=0: sdi = first bit. CPHA=1: sdi = 0.
  - If idx >= N_SLAVES, no cs line asserts, but the frame is still clocked.
- SHIFT (2*8N half-periods of H cycles; sclk toggles at each half-period boundary):
  - CPHA=0: sample sdo on leading edges; present next bit on trailing edges (no shift after the last).
  - CPHA=1: present bit on leading edges; sample sdo on trailing edges.
- HOLD (H cycles): sclk = CPOL, sdi = 0. Then cs all high.
- cs is low for exactly (16N+2)*H aclk cycles.
- Read disabled: s_axis_tready=1 in the cycle cs returns high.
- Read enabled (RESP):
  - m_axis_tvalid=1 with the 8N captured bits right-aligned; first sampled bit is bit 8N-1.
  - tdata/tvalid are held until m_axis_tready; tready may be high before tvalid, in which case the handshake completes in the first valid cycle.
  - s_axis_tready rises the cycle after the handshake.
- s_axis_tvalid while busy is ignored (tready low). Commands are never queued or dropped once accepted.

Optional Feature:
SPI_CFG_CS_GAP_EN:
- Defined: after cs returns high (or after the RESP handshake), s_axis_tready stays low for a further 2**CLK_DIV aclk cycles. This guarantees a minimum CS-high time between frames.
- Undefined: no gap; timing is as in Behaviour.

Test Plan:
- Mode 0 write: CLK_DIV=2, cmd=0x02, tdata=0xA5000000 -> cs=4'b1011 for 36 cycles; sdi at sclk rising edges = 1,0,1,0,0,1,0,1; 8 rising edges; no m_axis_tvalid; tready back high when cs rises.
- Read: cmd=0x25 (slave 1, 2 bytes, read), sdo model returns 0x3C5A -> cs=4'b1101 for 68 cycles; m_axis_tdata=0x00003C5A held with m_axis_tready low for 10 cycles; tready rises the cycle after the handshake.
- Mode 3 write: cmd=0xC0, tdata=0x81000000 -> sclk idles high before, during SETUP/HOLD and after; sdi changes on falling edges, is stable at rising edges, and reads 1,0,0,0,0,0,0,1.
- Clamp and invalid slave: N_SLAVES=2, cmd=0x1F (idx 3, nbytes field 7) -> cs stays 2'b11; 32 sclk cycles are generated; tready returns afterwards.
- Reset mid-frame: assert aresetn low at SHIFT bit 5 -> cs all ones, sclk=0, tready=0 asynchronously; a new 1-byte frame after release completes normally.
- CS gap (macro defined, CLK_DIV=3): back-to-back tvalid -> cs high for >= 8 aclk cycles between frames; without the macro, the next frame is accepted the cycle cs rises.

Source files
------------

// File: rtl/spi_cfg_rw.sv
// SPI configuration master: one command + data word in, 1..DATA_WIDTH/8 bytes out MSB first,
// optional read-back. Define SPI_CFG_CS_GAP_EN to enforce a minimum CS-high gap between frames.
module spi_cfg_rw #(
    parameter int unsigned CLK_DIV    = 3,
    parameter int unsigned N_SLAVES   = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [7:0]            cmd,
    output logic [N_SLAVES-1:0]   cs,
    output logic                  sclk,
    output logic                  sdi,
    input  logic                  sdo,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    localparam int unsigned CntW     = 8;
    localparam int unsigned HalfCyc  = 2 ** (CLK_DIV - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HalfCyc - 1);
    localparam logic [3:0]      MaxBytes = 4'(DATA_WIDTH / 8);
`ifdef SPI_CFG_CS_GAP_EN
    localparam logic [CntW-1:0] GapLast  = CntW'((2 ** CLK_DIV) - 1);
`endif

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StResp,
        StGap
    } state_e;

    state_e                  state_q;
    logic [CntW-1:0]         cnt_q;
    logic [7:0]              hp_q;
    logic [7:0]              hp_last_q;
    logic                    cpol_q;
    logic                    cpha_q;
    logic                    rd_q;
    logic [DATA_WIDTH-1:0]   tx_q;
    logic [DATA_WIDTH-1:0]   rx_q;
    logic [N_SLAVES-1:0]     cs_q;
    logic                    sclk_q;
    logic                    sdi_q;
    logic                    s_tready_q;
    logic                    m_tvalid_q;
    logic [DATA_WIDTH-1:0]   m_tdata_q;

    logic [3:0]              nbytes_raw;
    logic [3:0]              nbytes;
    logic [7:0]              hp_last_d;
    logic [N_SLAVES-1:0]     cs_sel_d;
    logic                    hp_end;
    logic                    lead_edge;
    logic                    trail_edge;
    logic                    last_trail;

    // Command decode; a slave index beyond N_SLAVES selects no line.
    always_comb begin
        nbytes_raw = {1'b0, cmd[4:2]} + 4'd1;
        nbytes     = (nbytes_raw > MaxBytes) ? MaxBytes : nbytes_raw;
        hp_last_d  = {nbytes, 4'b0000} - 8'd1;
        cs_sel_d   = '1;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (cmd[1:0] == 2'(i)) begin
                cs_sel_d[i] = 1'b0;
            end
        end
    end

    // Half-period k of SHIFT starts with a leading edge when k is even, trailing when odd.
    always_comb begin
        hp_end     = (cnt_q == '0);
        lead_edge  = hp_end && ((state_q == StSetup) ||
                     ((state_q == StShift) && hp_q[0] && (hp_q != hp_last_q)));
        trail_edge = hp_end && (state_q == StShift) && !hp_q[0];
        last_trail = trail_edge && ((hp_q + 8'd1) == hp_last_q);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            hp_q       <= '0;
            hp_last_q  <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            rd_q       <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            cs_q       <= '1;
            sclk_q     <= 1'b0;
            sdi_q      <= 1'b0;
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    s_tready_q <= 1'b1;
                    if (s_axis_tvalid && s_tready_q) begin
                        s_tready_q <= 1'b0;
                        cs_q       <= cs_sel_d;
                        sclk_q     <= cmd[6];
                        cpol_q     <= cmd[6];
                        cpha_q     <= cmd[7];
                        rd_q       <= cmd[5];
                        hp_last_q  <= hp_last_d;
                        hp_q       <= '0;
                        sdi_q      <= cmd[7] ? 1'b0 : s_axis_tdata[DATA_WIDTH-1];
                        tx_q       <= cmd[7] ? s_axis_tdata : (s_axis_tdata << 1);
                        rx_q       <= '0;
                        cnt_q      <= HalfLast;
                        state_q    <= StSetup;
                    end
                end
                StSetup: begin
                    if (hp_end) begin
                        cnt_q   <= HalfLast;
                        state_q <= StShift;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StShift: begin
                    if (hp_end) begin
                        cnt_q <= HalfLast;
                        if (hp_q == hp_last_q) begin
                            sdi_q   <= 1'b0;
                            state_q <= StHold;
                        end else begin
                            hp_q <= hp_q + 8'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StHold: begin
                    if (hp_end) begin
                        cs_q <= '1;
                        if (rd_q) begin
                            m_tvalid_q <= 1'b1;
                            m_tdata_q  <= rx_q;
                            state_q    <= StResp;
                        end else begin
`ifdef SPI_CFG_CS_GAP_EN
                            cnt_q      <= GapLast;
                            state_q    <= StGap;
`else
                            s_tready_q <= 1'b1;
                            state_q    <= StIdle;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StResp: begin
                    if (m_axis_tready) begin
                        m_tvalid_q <= 1'b0;
`ifdef SPI_CFG_CS_GAP_EN
                        cnt_q      <= GapLast;
                        state_q    <= StGap;
`else
                        s_tready_q <= 1'b1;
                        state_q    <= StIdle;
`endif
                    end
                end
`ifdef SPI_CFG_CS_GAP_EN
                StGap: begin
                    if (hp_end) begin
                        s_tready_q <= 1'b1;
                        state_q    <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase

            if (lead_edge) begin
                sclk_q <= ~cpol_q;
                if (cpha_q) begin
                    sdi_q <= tx_q[DATA_WIDTH-1];
                    tx_q  <= tx_q << 1;
                end else begin
                    rx_q <= {rx_q[DATA_WIDTH-2:0], sdo};
                end
            end

            // CPHA=0 keeps the final bit on the line through the last half-period.
            if (trail_edge) begin
                sclk_q <= cpol_q;
                if (cpha_q) begin
                    rx_q <= {rx_q[DATA_WIDTH-2:0], sdo};
                end else if (!last_trail) begin
                    sdi_q <= tx_q[DATA_WIDTH-1];
                    tx_q  <= tx_q << 1;
                end
            end
        end
    end

    assign cs            = cs_q;
    assign sclk          = sclk_q;
    assign sdi           = sdi_q;
    assign s_axis_tready = s_tready_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;

endmodule
